unified_mem: RTL and testbench

Single-port, word-organised unified memory that replaces the separate instruction and data memories at the top level of the pipelined CPU system. It serves an instruction-fetch port and a load/store port through valid/ready request handshakes with a fixed one-cycle read latency. Arbitration gives the data port priority, with a starvation guard for fetch. Depth, data width and the starvation limit are parametrised.

---
 rtl/unified_mem_pkg.sv | 28 ++
 rtl/unified_mem_arb.sv | 44 ++++
 rtl/unified_mem.sv | 101 ++++++++++
 tb/tb_unified_mem.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_pkg.sv
// Shared types and address decode for the unified instruction/data memory.
package unified_mem_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam int DEF_DATA_W = 32;
    localparam int STRB_W     = DEF_DATA_W / 8;

    typedef struct packed {
        logic [31:0] idx;
        logic        in_range;
    } word_loc_t;

    // Byte-offset bits are dropped, so misaligned addresses fall onto their word.
    function automatic word_loc_t word_loc(input logic [63:0] addr,
                                           input int          data_w,
                                           input int          depth);
        word_loc_t loc;
        loc.idx      = 32'(addr >> $clog2(data_w / 8));
        loc.in_range = addr < (64'(depth) * 64'(data_w / 8));
        return loc;
    endfunction

endpackage

// File: rtl/unified_mem_arb.sv
// Fetch/data arbiter: data wins ties unless fetch has lost STARVE_MAX times in a row.
// Latency: combinational grant; backpressure: loser sees ready low and must hold.
// Ready depends only on the valids and the starvation counter, never on payload.
module unified_mem_arb
    import unified_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic d_valid,
    output gnt_t gnt,
    output logic i_ready,
    output logic d_ready
);

    logic [3:0] starve_cnt;

    always_comb begin
        gnt = GNT_NONE;
        if (i_valid && d_valid)
            gnt = (starve_cnt == 4'(STARVE_MAX)) ? GNT_I : GNT_D;
        else if (i_valid)
            gnt = GNT_I;
        else if (d_valid)
            gnt = GNT_D;
    end

    assign i_ready = (gnt == GNT_I);
    assign d_ready = (gnt == GNT_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (i_valid && (gnt != GNT_I)) begin
            if (starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/unified_mem.sv
// Single-port unified memory serving fetch and load/store ports; UNIFIED_MEM_BYTE_WRITE_EN enables strobes.
// Latency: accepted in cycle N, registered response in N+1 for one cycle.
// Backpressure: one access per cycle via ready; responses cannot be stalled.
module unified_mem
    import unified_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_rsp_valid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    gnt_t                gnt;
    word_loc_t           i_loc;
    word_loc_t           d_loc;
    logic [IDX_W-1:0]    i_idx;
    logic [IDX_W-1:0]    d_idx;
    logic [NB-1:0]       wstrb_eff;
    logic                wr_en;
    logic [DATA_W-1:0]   mem [DEPTH];

    unified_mem_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .gnt     (gnt),
        .i_ready (i_req_ready),
        .d_ready (d_req_ready)
    );

    assign i_loc = word_loc(64'(i_addr), DATA_W, DEPTH);
    assign d_loc = word_loc(64'(d_addr), DATA_W, DEPTH);
    assign i_idx = i_loc.idx[IDX_W-1:0];
    assign d_idx = d_loc.idx[IDX_W-1:0];

    logic unused_idx_hi;
    assign unused_idx_hi = ^{i_loc.idx[31:IDX_W], d_loc.idx[31:IDX_W]};

`ifdef UNIFIED_MEM_BYTE_WRITE_EN
    assign wstrb_eff = d_wstrb;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^d_wstrb;
    assign wstrb_eff    = '1;
`endif

    // rst_n gate keeps a store presented during reset from landing in memory.
    assign wr_en = (gnt == GNT_D) && d_we && d_loc.in_range && rst_n;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_eff[b])
                    mem[d_idx][b*8 +: 8] <= d_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rsp_valid <= 1'b0;
            i_rdata     <= '0;
            d_rsp_valid <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
        end else begin
            i_rsp_valid <= (gnt == GNT_I);
            d_rsp_valid <= (gnt == GNT_D);
            if (gnt == GNT_I)
                i_rdata <= i_loc.in_range ? mem[i_idx] : '0;
            if (gnt == GNT_D) begin
                d_err   <= !d_loc.in_range;
                d_rdata <= (d_we || !d_loc.in_range) ? '0 : mem[d_idx];
            end
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Directed self-checking bench for unified_mem with hand-computed expectations.
module tb_unified_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rdata;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_w4;

    always #5 clk = ~clk;

    unified_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_addr      (i_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rdata     (i_rdata),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wstrb     (d_wstrb),
        .d_rsp_valid (d_rsp_valid),
        .d_rdata     (d_rdata),
        .d_err       (d_err)
    );

    // One-cycle data request issued 1ns after an edge; returns ready as seen before the accepting edge.
    task automatic d_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic rdy);
        d_req_valid = 1'b1;
        d_we        = we;
        d_addr      = addr;
        d_wdata     = wdata;
        d_wstrb     = strb;
        #1;
        rdy = d_req_ready;
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        d_we        = 1'b0;
    endtask

    task automatic i_op(input logic [31:0] addr, output logic rdy);
        i_req_valid = 1'b1;
        i_addr      = addr;
        #1;
        rdy = i_req_ready;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_addr = '0;
        d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        #23;
        checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_i_rsp_valid got %b want 0", i_rsp_valid); end
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_d_rsp_valid got %b want 0", d_rsp_valid); end
        checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata got %h want 0", i_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset_d_err got %b want 0", d_err); end
        checks++; if (dut.u_arb.starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve_cnt got %0d want 0", dut.u_arb.starve_cnt); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch;
        logic rdy;
        d_op(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL preload_ready got %b want 1", rdy); end
        i_op(32'h8, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fetch_ready got %b want 1", rdy); end
        checks++; if (i_rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_rsp_valid got %b want 1", i_rsp_valid); end
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got %h want deadbeef", i_rdata); end
        @(posedge clk); #1;
        checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_rsp_one_cycle got %b want 0", i_rsp_valid); end
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata_hold got %h want deadbeef", i_rdata); end
    endtask

    task automatic test_store_load;
        logic rdy;
        d_op(1'b1, 32'h10, 32'h11223344, 4'hF, rdy);
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL store_ack_valid got %b want 1", d_rsp_valid); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_ack_rdata got %h want 0", d_rdata); end
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL store_ack_err got %b want 0", d_err); end
        d_op(1'b0, 32'h10, 32'h0, 4'h0, rdy);
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b want 1", d_rsp_valid); end
        checks++; if (d_rdata !== 32'h11223344) begin errors++; $display("FAIL load_rdata got %h want 11223344", d_rdata); end
        exp_w4 = 32'h11223344;
    endtask

    task automatic test_strobe;
        logic rdy;
        d_op(1'b1, 32'h10, 32'hAABBCCDD, 4'h2, rdy);
`ifdef UNIFIED_MEM_BYTE_WRITE_EN
        exp_w4 = 32'h1122CC44;
`else
        exp_w4 = 32'hAABBCCDD;
`endif
        d_op(1'b0, 32'h10, 32'h0, 4'h0, rdy);
        checks++; if (d_rdata !== exp_w4) begin errors++; $display("FAIL strobe_rdata got %h want %h", d_rdata, exp_w4); end
        // Misaligned load truncates to the same word.
        d_op(1'b0, 32'h13, 32'h0, 4'h0, rdy);
        checks++; if (d_rdata !== exp_w4) begin errors++; $display("FAIL misaligned_rdata got %h want %h", d_rdata, exp_w4); end
    endtask

    task automatic test_out_of_range;
        logic rdy;
        d_op(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rdy);
        d_op(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, rdy);
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL last_word_err got %b want 0", d_err); end
        d_op(1'b1, 32'h1000, 32'h55555555, 4'hF, rdy);
        checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL oor_store_err got %b want 1", d_err); end
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL oor_store_valid got %b want 1", d_rsp_valid); end
        d_op(1'b0, 32'h0, 32'h0, 4'h0, rdy);
        checks++; if (d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_no_change got %h want cafef00d", d_rdata); end
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL inrange_load_err got %b want 0", d_err); end
        d_op(1'b0, 32'hFFC, 32'h0, 4'h0, rdy);
        checks++; if (d_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL last_word_rdata got %h want 0badf00d", d_rdata); end
        d_op(1'b0, 32'h1000, 32'h0, 4'h0, rdy);
        checks++; if (d_rdata !== 32'h0 || d_err !== 1'b1) begin errors++; $display("FAIL oor_load got rdata %h err %b want 0 1", d_rdata, d_err); end
        i_op(32'h1000, rdy);
        checks++; if (i_rsp_valid !== 1'b1 || i_rdata !== 32'h0) begin errors++; $display("FAIL oor_fetch got valid %b rdata %h want 1 0", i_rsp_valid, i_rdata); end
    endtask

    task automatic test_contention;
        logic exp_d;
        logic prev_d;
        prev_d = 1'b0;
        i_req_valid = 1'b1; i_addr = 32'h8;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            exp_d = ((c % 5) != 4);
            #1;
            checks++; if (d_req_ready !== exp_d || i_req_ready !== !exp_d) begin
                errors++; $display("FAIL grant_cycle%0d got d %b i %b want d %b", c, d_req_ready, i_req_ready, exp_d);
            end
            checks++; if (dut.u_arb.starve_cnt > 4'd4) begin errors++; $display("FAIL starve_bound got %0d want <=4", dut.u_arb.starve_cnt); end
            if (c > 0) begin
                checks++; if (d_rsp_valid !== prev_d || i_rsp_valid !== !prev_d) begin
                    errors++; $display("FAIL rsp_cycle%0d got d %b i %b want d %b", c, d_rsp_valid, i_rsp_valid, prev_d);
                end
            end
            prev_d = exp_d;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        checks++; if (d_rsp_valid !== 1'b0 || i_rsp_valid !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL contention_fetch got valid %b rdata %h want 1 deadbeef", i_rsp_valid, i_rdata);
        end
        checks++; if (d_rdata !== exp_w4) begin errors++; $display("FAIL contention_load got %h want %h", d_rdata, exp_w4); end
    endtask

    task automatic test_reset_mid;
        logic rdy;
        d_op(1'b0, 32'h10, 32'h0, 4'h0, rdy);
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", d_rsp_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (d_rsp_valid !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL async_reset got valid %b rdata %h want 0 0", d_rsp_valid, d_rdata);
        end
        // A store presented while reset is held must not land.
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h99999999; d_wstrb = 4'hF;
        @(posedge clk); #1;
        d_req_valid = 1'b0; d_we = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL post_release_valid got %b want 0", d_rsp_valid); end
        d_op(1'b0, 32'h10, 32'h0, 4'h0, rdy);
        checks++; if (d_rdata !== exp_w4) begin errors++; $display("FAIL reset_blocks_write got %h want %h", d_rdata, exp_w4); end
    endtask

    initial begin
        exp_w4 = 32'h0;
        test_reset;
        test_fetch;
        test_store_load;
        test_strobe;
        test_out_of_range;
        test_contention;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
